// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath control bus: instruction/memory status in, control strobes out.
// SINGLE_STEP_EN adds the step input used by the single-step build of control_sequencer.
interface control_sequencer_if;
  logic [31:0] IR_Data;
  logic        mem_ready;
`ifdef SINGLE_STEP_EN
  logic        step;
`endif
  logic        PC_select;
  logic        MAR_enable;
  logic        PC_increment_enable;
  logic        read;
  logic        MDR_enable;
  logic        MDR_select;
  logic        IR_enable;
  logic        Gra;
  logic        Grb;
  logic        BAout;
  logic        r_select;
  logic        r_enable;
  logic        Y_enable;
  logic        Z_enable;
  logic        Z_LO_select;
  logic        c_select;
  logic        inport_select;
  logic        outport_enable;
  logic [4:0]  alu_instruction;
  logic        run;
  logic        illegal;

  modport master (
`ifdef SINGLE_STEP_EN
    input  step,
`endif
    input  IR_Data, mem_ready,
    output PC_select, MAR_enable, PC_increment_enable, read, MDR_enable,
           MDR_select, IR_enable, Gra, Grb, BAout, r_select, r_enable,
           Y_enable, Z_enable, Z_LO_select, c_select, inport_select,
           outport_enable, alu_instruction, run, illegal
  );

  modport slave (
`ifdef SINGLE_STEP_EN
    output step,
`endif
    output IR_Data, mem_ready,
    input  PC_select, MAR_enable, PC_increment_enable, read, MDR_enable,
           MDR_select, IR_enable, Gra, Grb, BAout, r_select, r_enable,
           Y_enable, Z_enable, Z_LO_select, c_select, inport_select,
           outport_enable, alu_instruction, run, illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// Moore fetch/execute control sequencer for out/in/ldi/nop/halt.
// Optional macro SINGLE_STEP_EN inserts a WAIT state before every re-fetch, released by step.
module control_sequencer (
  input  logic                 clk,
  input  logic                 reset_n,
  control_sequencer_if.master  bus
);
  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH0,
    S_FETCH1,
    S_FETCH2,
    S_EXEC3,
    S_EXEC4,
    S_EXEC5,
    S_HALTED
`ifdef SINGLE_STEP_EN
    , S_WAIT
`endif
  } state_t;

  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] ALU_ADD = 5'b00011;

`ifdef SINGLE_STEP_EN
  localparam state_t NEXT_FETCH = S_WAIT;
`else
  localparam state_t NEXT_FETCH = S_FETCH0;
`endif

  state_t     state_q, state_d;
  logic [4:0] opc_q;
  logic       rdy_q;

  // mem_ready is registered so the fetch-exit decision (and the single PC
  // increment that goes with it) is a function of state registers only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RESET;
      opc_q   <= 5'b00000;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= bus.mem_ready;
      if (state_q == S_FETCH2) begin
        opc_q <= bus.IR_Data[31:27];
      end
    end
  end

  always_comb begin
    state_d                 = state_q;
    bus.PC_select           = 1'b0;
    bus.MAR_enable          = 1'b0;
    bus.PC_increment_enable = 1'b0;
    bus.read                = 1'b0;
    bus.MDR_enable          = 1'b0;
    bus.MDR_select          = 1'b0;
    bus.IR_enable           = 1'b0;
    bus.Gra                 = 1'b0;
    bus.Grb                 = 1'b0;
    bus.BAout               = 1'b0;
    bus.r_select            = 1'b0;
    bus.r_enable            = 1'b0;
    bus.Y_enable            = 1'b0;
    bus.Z_enable            = 1'b0;
    bus.Z_LO_select         = 1'b0;
    bus.c_select            = 1'b0;
    bus.inport_select       = 1'b0;
    bus.outport_enable      = 1'b0;
    bus.alu_instruction     = 5'b00000;
    bus.run                 = (state_q != S_HALTED);
    bus.illegal             = 1'b0;

    case (state_q)
      S_RESET: begin
        state_d = S_FETCH0;
      end
      S_FETCH0: begin
        bus.PC_select  = 1'b1;
        bus.MAR_enable = 1'b1;
        state_d        = S_FETCH1;
      end
      S_FETCH1: begin
        bus.read                = 1'b1;
        bus.MDR_enable          = 1'b1;
        bus.PC_increment_enable = rdy_q;
        if (rdy_q) begin
          state_d = S_FETCH2;
        end
      end
      S_FETCH2: begin
        bus.MDR_select = 1'b1;
        bus.IR_enable  = 1'b1;
        state_d        = S_EXEC3;
      end
      S_EXEC3: begin
        state_d = NEXT_FETCH;
        case (opc_q)
          OP_OUT: begin
            bus.Gra            = 1'b1;
            bus.r_select       = 1'b1;
            bus.outport_enable = 1'b1;
          end
          OP_IN: begin
            bus.Gra           = 1'b1;
            bus.r_enable      = 1'b1;
            bus.inport_select = 1'b1;
          end
          OP_LDI: begin
            bus.Grb      = 1'b1;
            bus.BAout    = 1'b1;
            bus.Y_enable = 1'b1;
            state_d      = S_EXEC4;
          end
          OP_NOP: begin
          end
          OP_HALT: begin
            state_d = S_HALTED;
          end
          default: begin
            bus.illegal = 1'b1;
          end
        endcase
      end
      S_EXEC4: begin
        bus.c_select        = 1'b1;
        bus.alu_instruction = ALU_ADD;
        bus.Z_enable        = 1'b1;
        state_d             = S_EXEC5;
      end
      S_EXEC5: begin
        bus.Z_LO_select = 1'b1;
        bus.Gra         = 1'b1;
        bus.r_enable    = 1'b1;
        state_d         = NEXT_FETCH;
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
`ifdef SINGLE_STEP_EN
      S_WAIT: begin
        if (bus.step) begin
          state_d = S_FETCH0;
        end
      end
`endif
      default: begin
        state_d = S_RESET;
      end
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed table, random instruction mix,
// and hand sequences for async reset, halt and (SINGLE_STEP_EN builds) single stepping.
module tb_control_sequencer;
  typedef logic [24:0] vec_t;

  localparam vec_t M_PC   = vec_t'(1) << 24;
  localparam vec_t M_MAR  = vec_t'(1) << 23;
  localparam vec_t M_INC  = vec_t'(1) << 22;
  localparam vec_t M_RD   = vec_t'(1) << 21;
  localparam vec_t M_MDRE = vec_t'(1) << 20;
  localparam vec_t M_MDRS = vec_t'(1) << 19;
  localparam vec_t M_IRE  = vec_t'(1) << 18;
  localparam vec_t M_GRA  = vec_t'(1) << 17;
  localparam vec_t M_GRB  = vec_t'(1) << 16;
  localparam vec_t M_BA   = vec_t'(1) << 15;
  localparam vec_t M_RSEL = vec_t'(1) << 14;
  localparam vec_t M_REN  = vec_t'(1) << 13;
  localparam vec_t M_YE   = vec_t'(1) << 12;
  localparam vec_t M_ZE   = vec_t'(1) << 11;
  localparam vec_t M_ZLO  = vec_t'(1) << 10;
  localparam vec_t M_CS   = vec_t'(1) << 9;
  localparam vec_t M_INS  = vec_t'(1) << 8;
  localparam vec_t M_OUTE = vec_t'(1) << 7;
  localparam vec_t M_ADD  = vec_t'(5'b00011) << 2;
  localparam vec_t M_RUN  = vec_t'(1) << 1;
  localparam vec_t M_ILL  = vec_t'(1);

  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] OP_BAD  = 5'b11111;

`ifdef SINGLE_STEP_EN
  localparam int STEP_EXTRA = 1;
`else
  localparam int STEP_EXTRA = 0;
`endif

  typedef struct {
    logic [31:0] ir;
    int          waits;
    int          exp_lat;
    int          exp_ill;
    int          exp_inc;
    int          exp_rd;
  } rec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  control_sequencer_if bus ();

  control_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  int   n_checks = 0;
  int   n_err = 0;
  bit   pending = 1'b0;
  vec_t exp_q[$];
  vec_t dut_vec;

  assign dut_vec = {bus.PC_select, bus.MAR_enable, bus.PC_increment_enable, bus.read,
                    bus.MDR_enable, bus.MDR_select, bus.IR_enable, bus.Gra, bus.Grb,
                    bus.BAout, bus.r_select, bus.r_enable, bus.Y_enable, bus.Z_enable,
                    bus.Z_LO_select, bus.c_select, bus.inport_select, bus.outport_enable,
                    bus.alu_instruction, bus.run, bus.illegal};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle control vectors of one instruction, straight from the state table.
  task automatic build_model(input logic [4:0] op, input int w);
    exp_q.delete();
    exp_q.push_back(M_RUN | M_PC | M_MAR);
    for (int k = 0; k <= w; k++) begin
      exp_q.push_back(M_RUN | M_RD | M_MDRE | ((k == w) ? M_INC : vec_t'(0)));
    end
    exp_q.push_back(M_RUN | M_MDRS | M_IRE);
    case (op)
      OP_OUT:  exp_q.push_back(M_RUN | M_GRA | M_RSEL | M_OUTE);
      OP_IN:   exp_q.push_back(M_RUN | M_GRA | M_REN | M_INS);
      OP_LDI: begin
        exp_q.push_back(M_RUN | M_GRB | M_BA | M_YE);
        exp_q.push_back(M_RUN | M_CS | M_ADD | M_ZE);
        exp_q.push_back(M_RUN | M_ZLO | M_GRA | M_REN);
      end
      OP_NOP, OP_HALT: exp_q.push_back(M_RUN);
      default: exp_q.push_back(M_RUN | M_ILL);
    endcase
    if (STEP_EXTRA != 0 && op != OP_HALT) begin
      exp_q.push_back(M_RUN);
    end
  endtask

  // Runs one instruction starting at FETCH0; memory answers after w wait cycles.
  task automatic run_instr(input logic [31:0] ir, input int w, input bit no_ret,
                           output int lat, output int ill, output int inc, output int rd);
    int len;
    bit found;
    build_model(ir[31:27], w);
    len = exp_q.size();
    ill = 0;
    inc = 0;
    rd  = 0;
    for (int i = 0; i < len; i++) begin
      if (i > 0 || !pending) @(negedge clk);
      chk($sformatf("cycle%0d op=%b w=%0d", i, ir[31:27], w), 32'(dut_vec), 32'(exp_q[i]));
      ill += int'(bus.illegal);
      inc += int'(bus.PC_increment_enable);
      rd  += int'(bus.read);
      bus.mem_ready = (i < w) ? 1'b0 : ((i == w) ? 1'b1 : 1'($urandom));
      bus.IR_Data   = (i < w + 4) ? ir : $urandom;
    end
    pending = 1'b0;
    lat = len;
    if (!no_ret) begin
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
        @(negedge clk);
        if (bus.PC_select) found = 1'b1;
        else lat++;
      end
      chk("next fetch seen", 32'(found), 32'd1);
      pending = found;
    end
    $display("instr ir=%h waits=%0d cycles=%0d illegal=%0d", ir, w, lat, ill);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.mem_ready = 1'b0;
    bus.IR_Data = $urandom;
    repeat (2) @(negedge clk);
    chk("reset outputs", 32'(dut_vec), 32'(M_RUN));
    reset_n = 1'b1;
    pending = 1'b0;
  endtask

  rec_t tbl[8];

  initial begin
    int lat, ill, inc, rd;
    int r;
    logic [4:0] op;
    logic [31:0] ir;

    tbl[0] = '{32'hB8800000, 0, 4 + STEP_EXTRA, 0, 1, 1};
    tbl[1] = '{32'hB8800000, 3, 7 + STEP_EXTRA, 0, 1, 4};
    tbl[2] = '{32'hB0000000, 1, 5 + STEP_EXTRA, 0, 1, 2};
    tbl[3] = '{32'h08880005, 0, 6 + STEP_EXTRA, 0, 1, 1};
    tbl[4] = '{32'hD0000000, 0, 4 + STEP_EXTRA, 0, 1, 1};
    tbl[5] = '{32'hF8000000, 0, 4 + STEP_EXTRA, 1, 1, 1};
    tbl[6] = '{32'h08880005, 2, 8 + STEP_EXTRA, 0, 1, 3};
    tbl[7] = '{32'h00000000, 1, 5 + STEP_EXTRA, 1, 1, 2};

`ifdef SINGLE_STEP_EN
    bus.step = 1'b1;
`endif
    do_reset();

    for (int t = 0; t < 8; t++) begin
      run_instr(tbl[t].ir, tbl[t].waits, 1'b0, lat, ill, inc, rd);
      chk($sformatf("t%0d latency", t), 32'(lat), 32'(tbl[t].exp_lat));
      chk($sformatf("t%0d illegal", t), 32'(ill), 32'(tbl[t].exp_ill));
      chk($sformatf("t%0d pc_inc", t), 32'(inc), 32'(tbl[t].exp_inc));
      chk($sformatf("t%0d read", t), 32'(rd), 32'(tbl[t].exp_rd));
    end

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 4);
      case (r)
        0: op = OP_OUT;
        1: op = OP_IN;
        2: op = OP_LDI;
        3: op = OP_NOP;
        default: begin
          op = 5'($urandom);
          if (op == OP_HALT) op = OP_BAD;
        end
      endcase
      ir = {op, 27'($urandom)};
      run_instr(ir, $urandom_range(0, 3), 1'b0, lat, ill, inc, rd);
    end

    // Asynchronous reset in the middle of ldi EXEC4.
    do_reset();
    @(negedge clk);
    chk("fetch0 after reset", 32'(bus.PC_select), 32'd1);
    bus.IR_Data = 32'h08880005;
    bus.mem_ready = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("ldi exec4", 32'(dut_vec), 32'(M_RUN | M_CS | M_ADD | M_ZE));
    reset_n = 1'b0;
    #1;
    chk("async reset mid-ldi", 32'(dut_vec), 32'(M_RUN));
    @(negedge clk);
    chk("reset held", 32'(dut_vec), 32'(M_RUN));
    reset_n = 1'b1;
    @(negedge clk);
    chk("fetch0 after release", 32'(dut_vec), 32'(M_RUN | M_PC | M_MAR));
    pending = 1'b1;

    // halt stays halted with everything low.
    run_instr(32'hD8000000, 1, 1'b1, lat, ill, inc, rd);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("halted cycle%0d", c), 32'(dut_vec), 32'd0);
      bus.mem_ready = 1'($urandom);
      bus.IR_Data = $urandom;
    end

    do_reset();
    run_instr(32'hB8800000, 0, 1'b0, lat, ill, inc, rd);
    chk("out after halt reset", 32'(lat), 32'(4 + STEP_EXTRA));

`ifdef SINGLE_STEP_EN
    // step held low after a nop parks the sequencer; one pulse runs one instruction.
    bus.step = 1'b0;
    run_instr(32'hD0000000, 0, 1'b1, lat, ill, inc, rd);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("wait cycle%0d", c), 32'(dut_vec), 32'(M_RUN));
    end
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    chk("step fetch", 32'(dut_vec), 32'(M_RUN | M_PC | M_MAR));
    pending = 1'b1;
    run_instr(32'hD0000000, 0, 1'b1, lat, ill, inc, rd);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("post-step wait%0d", c), 32'(dut_vec), 32'(M_RUN));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
